// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction prefetch queue for the 5-stage LC-3b pipe, in place of the
// single-entry IF-ID latch. The block owns the fetch PC and the
// instruction-memory handshake. It buffers up to DEPTH fetched
// {ir, pc+2} pairs ahead of decode.
//
// Redirects flush the queue. A redirect that arrives while a memory request
// is outstanding moves the FSM to DRAIN. DRAIN keeps the old request stable,
// throws its response away, and only then restarts fetch at the saved target.
//
// Ports
//   clk, rst      clock (rising edge) and asynchronous active-high reset
//   imem_addr     instruction memory address (current fetch PC)
//   imem_read     instruction memory read request
//   imem_resp     one-cycle response strobe; imem_rdata is valid in that cycle
//   imem_rdata    fetched instruction word
//   redirect      flush the queue and restart fetch at redirect_pc
//   redirect_pc   new fetch PC (bit 0 is ignored)
//   deq           decode consumes the head entry this cycle
//   valid         head entry present
//   ir            head instruction; 0 (BR never, a NOP) when empty
//   pc_plus2      head entry fetch address + 2; 0 when empty
//   count         number of occupied entries
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int                 WIDTH    = 16,
    parameter int                 DEPTH    = 4,
    parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [WIDTH-1:0]             imem_addr,
    output logic                         imem_read,
    input  logic                         imem_resp,
    input  logic [WIDTH-1:0]             imem_rdata,
    input  logic                         redirect,
    input  logic [WIDTH-1:0]             redirect_pc,
    input  logic                         deq,
    output logic                         valid,
    output logic [WIDTH-1:0]             ir,
    output logic [WIDTH-1:0]             pc_plus2,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t             state_q,      state_d;
    logic [WIDTH-1:0]   fetch_pc_q,   fetch_pc_d;
    logic [WIDTH-1:0]   pending_pc_q, pending_pc_d;
    logic [PTR_W-1:0]   head_q,       head_d;
    logic [PTR_W-1:0]   tail_q,       tail_d;
    logic [CNT_W-1:0]   count_q,      count_d;

    logic [WIDTH-1:0]   ir_mem_q  [DEPTH];
    logic [WIDTH-1:0]   pc2_mem_q [DEPTH];

    logic               read_req;
    logic               enq;
    logic               deq_ok;
    logic [WIDTH-1:0]   redirect_target;

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pending_pc_d = pending_pc_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        enq          = 1'b0;
        deq_ok       = 1'b0;

        // In DRAIN the abandoned request has to stay up until its response.
        // In FETCH, free space can only grow while a request is pending, so
        // once the request is raised it stays raised.
        read_req        = (state_q == DRAIN) || (count_q < CNT_W'(DEPTH));
        redirect_target = redirect_pc & ~WIDTH'(1);

        if (redirect) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            if (read_req && !imem_resp) begin
                // A request is still outstanding: park the target until the
                // stale response has come back.
                state_d      = DRAIN;
                pending_pc_d = redirect_target;
            end else begin
                state_d    = FETCH;
                fetch_pc_d = redirect_target;
            end
        end else begin
            if (state_q == FETCH) begin
                if (read_req && imem_resp) begin
                    enq        = 1'b1;
                    tail_d     = tail_q + PTR_W'(1);
                    fetch_pc_d = fetch_pc_q + WIDTH'(2);
                end
            end else if (imem_resp) begin
                state_d    = FETCH;
                fetch_pc_d = pending_pc_q;
            end

            if (deq && (count_q != '0)) begin
                deq_ok = 1'b1;
                head_d = head_q + PTR_W'(1);
            end

            count_d = count_q + CNT_W'(enq) - CNT_W'(deq_ok);
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every flop
    // samples values from before the edge regardless of evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FETCH;
            fetch_pc_q   <= RESET_PC;
            pending_pc_q <= RESET_PC;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pending_pc_q <= pending_pc_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
        end
    end

    // NOTE: the entry storage is deliberately not reset. count gates every
    // read, so stale contents are never visible, and leaving the reset off
    // lets the array map to plain storage.
    always_ff @(posedge clk) begin
        if (enq) begin
            ir_mem_q[tail_q]  <= imem_rdata;
            pc2_mem_q[tail_q] <= fetch_pc_q + WIDTH'(2);
        end
    end

    // Gating imem_read with rst drops the request as soon as reset asserts,
    // and keeps it low for as long as reset is held.
    assign imem_read = read_req & ~rst;
    assign imem_addr = fetch_pc_q;

    assign valid    = (count_q != '0);
    assign count    = count_q;
    assign ir       = valid ? ir_mem_q[head_q]  : '0;
    assign pc_plus2 = valid ? pc2_mem_q[head_q] : '0;

endmodule
